// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch address map, nop encoding and the IF/ID latch record.
// Fetch-path helpers keep the address-window arithmetic in one place.
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] BASE_ADDR = 32'h0040_0000;
    localparam int          IMEM_AW   = 11;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        fault;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        valid: 1'b0,
        instr: NOP_INSTR,
        pc:    32'h0,
        pc4:   32'h0,
        fault: 1'b0
    };

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_HOLD = 2'd1,
        PC_BR   = 2'd2,
        PC_EXC  = 2'd3
    } pc_sel_e;

    // Any set bit above the window means out of range; PCs below BASE_ADDR wrap high and land here too.
    function automatic logic fetch_out_of_window(input logic [31:0] offset);
        return offset[31:IMEM_AW+2] != '0;
    endfunction

    function automatic logic fetch_fault(input logic [31:0] pc);
        logic [31:0] offset;
        offset = pc - BASE_ADDR;
        return (pc[1:0] != 2'b00) || fetch_out_of_window(offset);
    endfunction

    function automatic logic [IMEM_AW-1:0] word_index(input logic [31:0] pc);
        logic [31:0] offset;
        offset = pc - BASE_ADDR;
        return offset[IMEM_AW+1:2];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: async reset to bubble, flush to bubble, hold on stall.
// Flush wins over stall so a redirect is never lost behind a hazard hold.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= IFID_BUBBLE;
        end else if (flush) begin
            q <= IFID_BUBBLE;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch fault check and IF/ID latch.
// imem_addr comes from the registered PC only, so no input reaches it combinationally.
module if_fetch_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               br_redirect,
    input  logic [31:0]        br_target,
    input  logic               exc_redirect,
    input  logic [31:0]        exc_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        pc_out,
    output logic               id_valid,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc4,
    output logic               id_fault
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        fault;
    logic        redirect;
    pc_sel_e     pc_sel;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

    assign pc_plus4  = pc + 32'd4;
    assign fault     = fetch_fault(pc);
    assign imem_addr = word_index(pc);
    assign pc_out    = pc;
    assign redirect  = exc_redirect | br_redirect;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pc_sel = PC_SEQ;
        if (exc_redirect) begin
            pc_sel = PC_EXC;
        end else if (br_redirect) begin
            pc_sel = PC_BR;
        end else if (stall) begin
            pc_sel = PC_HOLD;
        end
    end

    always_comb begin
        pc_next = pc_plus4;
        unique case (pc_sel)
            PC_EXC:  pc_next = exc_target;
            PC_BR:   pc_next = br_target;
            PC_HOLD: pc_next = pc;
            default: pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // A faulting fetch still enters IF/ID as a valid slot so CP0 sees the fault with its PC.
    always_comb begin
        ifid_d.valid = 1'b1;
        ifid_d.instr = fault ? NOP_INSTR : imem_data;
        ifid_d.pc    = pc;
        ifid_d.pc4   = pc_plus4;
        ifid_d.fault = fault;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (redirect),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign id_valid = ifid_q.valid;
    assign id_instr = ifid_q.instr;
    assign id_pc    = ifid_q.pc;
    assign id_pc4   = ifid_q.pc4;
    assign id_fault = ifid_q.fault;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, stall, branch, exception priority and fault window.
// Instruction memory word k holds 32'h1000_0000 + k so fetched words identify their index.
module tb_if_fetch_stage;
    import cpu_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               stall;
    logic               br_redirect;
    logic [31:0]        br_target;
    logic               exc_redirect;
    logic [31:0]        exc_target;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic [31:0]        pc_out;
    logic               id_valid;
    logic [31:0]        id_instr;
    logic [31:0]        id_pc;
    logic [31:0]        id_pc4;
    logic               id_fault;

    logic [31:0] imem [0:(1<<IMEM_AW)-1];
    int n_cmp;
    int n_err;

    if_fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .br_redirect  (br_redirect),
        .br_target    (br_target),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .pc_out       (pc_out),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_pc4       (id_pc4),
        .id_fault     (id_fault)
    );

    assign imem_data = imem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, ".valid"}, {31'b0, id_valid}, 32'd1);
        check({tag, ".pc"},    id_pc,    pc);
        check({tag, ".pc4"},   id_pc4,   pc + 32'd4);
        check({tag, ".instr"}, id_instr, instr);
        check({tag, ".fault"}, {31'b0, id_fault}, 32'd0);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"}, {31'b0, id_valid}, 32'd0);
        check({tag, ".instr"}, id_instr, 32'h0);
        check({tag, ".pc"},    id_pc,    32'h0);
        check({tag, ".pc4"},   id_pc4,   32'h0);
        check({tag, ".fault"}, {31'b0, id_fault}, 32'd0);
    endtask

    task automatic redirect_br(input logic [31:0] target);
        br_redirect = 1'b1;
        br_target   = target;
        step();
        br_redirect = 1'b0;
    endtask

    logic [31:0] exp_pc   [0:3];
    logic [31:0] exp_word [0:3];

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < (1 << IMEM_AW); i++) imem[i] = 32'h1000_0000 + i;
        exp_pc   = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C};
        exp_word = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003};

        rst_n = 1'b0; stall = 1'b0;
        br_redirect = 1'b0; br_target = 32'h0;
        exc_redirect = 1'b0; exc_target = 32'h0;
        #12;
        check("rst0.pc", pc_out, 32'h0040_0000);
        check_bubble("rst0");

        step();
        rst_n = 1'b1;
        step();
        check_id("run0", 32'h0040_0000, 32'h1000_0000);
        step();
        step();
        check("run2.pc", pc_out, 32'h0040_000C);

        // Asynchronous reset mid-run takes effect without waiting for an edge.
        rst_n = 1'b0;
        #1;
        check("rst1.pc", pc_out, 32'h0040_0000);
        check("rst1.valid", {31'b0, id_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_id($sformatf("seq%0d", i), exp_pc[i], exp_word[i]);
        end
        check("seq.pc", pc_out, 32'h0040_0010);

        // Reposition so that pc=0x00400008 with id_pc=0x00400004, then stall three cycles.
        redirect_br(32'h0040_0004);
        step();
        check("pre_stall.pc", pc_out, 32'h0040_0008);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_id($sformatf("stall%0d", i), 32'h0040_0004, 32'h1000_0001);
            check($sformatf("stall%0d.addr", i), {21'b0, imem_addr}, 32'd2);
            check($sformatf("stall%0d.pc", i), pc_out, 32'h0040_0008);
        end
        stall = 1'b0;
        step();
        check_id("unstall", 32'h0040_0008, 32'h1000_0002);
        check("unstall.pc", pc_out, 32'h0040_000C);

        redirect_br(32'h0040_0100);
        check("br.pc", pc_out, 32'h0040_0100);
        check_bubble("br");
        step();
        check_id("br_tgt", 32'h0040_0100, 32'h1000_0040);

        stall = 1'b1;
        redirect_br(32'h0040_0200);
        stall = 1'b0;
        check("br_stall.pc", pc_out, 32'h0040_0200);
        check_bubble("br_stall");
        step();
        check_id("br_stall_tgt", 32'h0040_0200, 32'h1000_0080);

        exc_redirect = 1'b1;
        exc_target   = 32'h0040_0004;
        redirect_br(32'h0040_0100);
        exc_redirect = 1'b0;
        check("exc.pc", pc_out, 32'h0040_0004);
        check_bubble("exc");
        step();
        check_id("exc_tgt", 32'h0040_0004, 32'h1000_0001);

        redirect_br(32'h0040_0002);
        step();
        check("mis.valid", {31'b0, id_valid}, 32'd1);
        check("mis.fault", {31'b0, id_fault}, 32'd1);
        check("mis.instr", id_instr, 32'h0);
        check("mis.pc",    id_pc,    32'h0040_0002);
        check("mis.nextpc", pc_out,  32'h0040_0006);

        redirect_br(32'h0040_2000);
        step();
        check("oow.fault", {31'b0, id_fault}, 32'd1);
        check("oow.instr", id_instr, 32'h0);

        redirect_br(32'h0040_1FFC);
        check("last.addr", {21'b0, imem_addr}, 32'd2047);
        step();
        check_id("last", 32'h0040_1FFC, 32'h1000_07FF);
        step();
        check("past.fault", {31'b0, id_fault}, 32'd1);

        redirect_br(32'hFFFF_FFFC);
        step();
        check("top.fault", {31'b0, id_fault}, 32'd1);
        check("top.pc4",   id_pc4,   32'h0);
        check("wrap.pc",   pc_out,   32'h0);
        step();
        check("low.fault", {31'b0, id_fault}, 32'd1);
        check("low.pc",    id_pc,    32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
